// File: rtl/addmul_pkg.sv
// Shared types and constants for the sequential add/multiply unit.
package addmul_pkg;

  // Operation codes carried on the op input.
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_MUL  = 2'b01,
    OP_RSV2 = 2'b10,
    OP_RSV3 = 2'b11
  } op_e;

  // Control states of the unit.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Width of the optional retired-transaction counter.
  localparam int OPCNT_W = 16;

endpackage

// File: rtl/shift_add_mul_core.sv
// Iterative shift-add multiplier: one bit of b per cycle, WIDTH cycles total.
// 'last' flags the cycle whose clock edge completes the final iteration; 'prod'
// is the accumulator value that edge will hold, so the caller can register it
// on the same edge without an extra cycle.
module shift_add_mul_core #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  logic                 busy_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   pp [WIDTH];

  // One pre-shifted partial product per multiplier bit; the counter selects one.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
    assign pp[gi] = b_q[gi] ? (a_q << gi) : '0;
  end

  // Accumulator update for the iteration currently selected by the counter.
  always_comb begin
    acc_d = acc_q + pp[cnt_q];
  end

  assign last = busy_q && (cnt_q == LAST_IDX);
  assign prod = acc_d;

  // Operand capture on start, then WIDTH fixed iterations regardless of data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      a_q    <= {{WIDTH{1'b0}}, a};
      b_q    <= b;
      acc_q  <= '0;
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == LAST_IDX) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_addmul_unit.sv
// Sequential add/multiply unit with valid/ready on both sides.
// ADD and reserved opcodes complete in one cycle; MUL runs WIDTH iterations
// in shift_add_mul_core. Only one transaction is ever in flight.
// Optional macro ADDMUL_OPCNT_EN adds a saturating op_count output that counts
// every retired transaction.
module seq_addmul_unit
  import addmul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               err
`ifdef ADDMUL_OPCNT_EN
  ,
  output logic [OPCNT_W-1:0] op_count
`endif
);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 err_q, err_d;
  logic                 accept;
  logic                 retire;
  logic                 mul_start;
  logic                 core_last;
  logic [2*WIDTH-1:0]   core_prod;
  logic [WIDTH:0]       sum;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign err       = err_q;
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;
  assign sum       = {1'b0, a} + {1'b0, b};

  shift_add_mul_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .start(mul_start),
    .a    (a),
    .b    (b),
    .last (core_last),
    .prod (core_prod)
  );

  // Next-state, result/err capture and multiplier launch.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    err_d     = err_q;
    mul_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_e'(op))
            OP_ADD: begin
              result_d = {{(WIDTH-1){1'b0}}, sum};
              err_d    = 1'b0;
              state_d  = S_DONE;
            end
            OP_MUL: begin
              mul_start = 1'b1;
              err_d     = 1'b0;
              state_d   = S_BUSY;
            end
            default: begin
              result_d = '0;
              err_d    = 1'b1;
              state_d  = S_DONE;
            end
          endcase
        end
      end
      S_BUSY: begin
        if (core_last) begin
          result_d = core_prod;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (retire) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; results hold stable while DONE waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

`ifdef ADDMUL_OPCNT_EN
  logic [OPCNT_W-1:0] op_cnt_q;

  // Saturating count of retired transactions, reserved opcodes included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q <= '0;
    end else if (retire && (op_cnt_q != {OPCNT_W{1'b1}})) begin
      op_cnt_q <= op_cnt_q + OPCNT_W'(1);
    end
  end

  assign op_count = op_cnt_q;
`endif

endmodule

// File: tb/tb_seq_addmul_unit.sv
// Directed bench for seq_addmul_unit (WIDTH=4); op_count checks are built
// only when ADDMUL_OPCNT_EN is defined.
module tb_seq_addmul_unit;
  import addmul_pkg::*;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [1:0]     op;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           err;
`ifdef ADDMUL_OPCNT_EN
  logic [OPCNT_W-1:0] op_count;
`endif

  int applied;
  int miscompares;

  seq_addmul_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .err      (err)
`ifdef ADDMUL_OPCNT_EN
    ,
    .op_count (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one transaction with out_ready high; lat counts edges from the accept
  // edge until out_valid is seen (ADD = 1, MUL = W+1). Retires before returning.
  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [1:0] top, output int lat,
                         output logic [2*W-1:0] res, output logic terr);
    int guard;
    a = ta;
    b = tb_v;
    op = top;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    res = result;
    terr = err;
    if (out_valid) step();
  endtask

  task automatic test_reset();
    logic saw;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; op = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    applied++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    applied++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    applied++; if (result !== 8'd0) begin miscompares++; $display("FAIL reset_result: got %0d expected 0", result); end
    applied++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err); end
    $display("reset: in_ready=%b out_valid=%b result=%0d err=%b", in_ready, out_valid, result, err);

    // MUL 7*3, reset asserted during the third BUSY cycle.
    step();
    a = 4'd7; b = 4'd3; op = 2'b01; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    saw = out_valid;
    step();
    saw |= out_valid;
    step();
    saw |= out_valid;
    rst_n = 1'b0;
    #1;
    applied++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL async_reset_in_ready: got %b expected 1", in_ready); end
    repeat (2) begin step(); saw |= out_valid; end
    rst_n = 1'b1;
    repeat (6) begin step(); saw |= out_valid; end
    applied++; if (saw !== 1'b0) begin miscompares++; $display("FAIL midop_reset_out_valid: got %b expected 0", saw); end
    applied++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midop_reset_in_ready: got %b expected 1", in_ready); end
    $display("midop reset: out_valid_seen=%b in_ready=%b", saw, in_ready);
  endtask

  task automatic test_add();
    int lat; logic [2*W-1:0] res; logic e;
    run_txn(4'd3, 4'd3, 2'b00, lat, res, e);
    applied++; if (lat !== 1) begin miscompares++; $display("FAIL add_latency: got %0d expected 1", lat); end
    applied++; if (res !== 8'd6) begin miscompares++; $display("FAIL add_result: got %0d expected 6", res); end
    applied++; if (e !== 1'b0) begin miscompares++; $display("FAIL add_err: got %b expected 0", e); end
    applied++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL add_in_ready_after: got %b expected 1", in_ready); end
    $display("add 3+3: lat=%0d result=%0d err=%b", lat, res, e);
  endtask

  task automatic test_mul();
    int lat; logic [2*W-1:0] res; logic e;
    run_txn(4'd4, 4'd5, 2'b01, lat, res, e);
    applied++; if (lat !== 5) begin miscompares++; $display("FAIL mul_latency: got %0d expected 5", lat); end
    applied++; if (res !== 8'd20) begin miscompares++; $display("FAIL mul_result: got %0d expected 20", res); end
    applied++; if (e !== 1'b0) begin miscompares++; $display("FAIL mul_err: got %b expected 0", e); end
    $display("mul 4*5: lat=%0d result=%0d err=%b", lat, res, e);
    run_txn(4'd0, 4'd9, 2'b01, lat, res, e);
    applied++; if (lat !== 5) begin miscompares++; $display("FAIL mul_zero_latency: got %0d expected 5", lat); end
    applied++; if (res !== 8'd0) begin miscompares++; $display("FAIL mul_zero_result: got %0d expected 0", res); end
    $display("mul 0*9: lat=%0d result=%0d", lat, res);
    run_txn(4'd13, 4'd11, 2'b01, lat, res, e);
    applied++; if (res !== 8'd143) begin miscompares++; $display("FAIL mul_13x11: got %0d expected 143", res); end
    $display("mul 13*11: lat=%0d result=%0d", lat, res);
  endtask

  task automatic test_boundaries();
    int lat; logic [2*W-1:0] res; logic e;
    run_txn(4'd15, 4'd15, 2'b01, lat, res, e);
    applied++; if (res !== 8'd225) begin miscompares++; $display("FAIL mul_max: got %0d expected 225", res); end
    $display("mul 15*15: lat=%0d result=%0d", lat, res);
    run_txn(4'd15, 4'd15, 2'b00, lat, res, e);
    applied++; if (res !== 8'd30) begin miscompares++; $display("FAIL add_max: got %0d expected 30", res); end
    $display("add 15+15: lat=%0d result=%0d", lat, res);
  endtask

  task automatic test_back_to_back();
    int acc1, ret1, acc2;
    logic [2*W-1:0] res1, res2;
    acc1 = -1; ret1 = -1; acc2 = -1;
    res1 = '1; res2 = '1;
    out_ready = 1'b1;
    a = 4'd1; b = 4'd2; op = 2'b00;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid && acc2 >= 0 && res2 === 8'hFF) res2 = result;
      if (out_valid && acc1 >= 0 && ret1 < 0) begin res1 = result; ret1 = c; end
      if (in_valid && in_ready) begin
        if (acc1 < 0) acc1 = c;
        else if (acc2 < 0) acc2 = c;
      end
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    applied++; if (ret1 - acc1 !== 1) begin miscompares++; $display("FAIL b2b_first_retire: got %0d expected 1", ret1 - acc1); end
    applied++; if (acc2 - ret1 !== 1) begin miscompares++; $display("FAIL b2b_second_accept: got %0d expected 1", acc2 - ret1); end
    applied++; if (res1 !== 8'd3) begin miscompares++; $display("FAIL b2b_first_result: got %0d expected 3", res1); end
    applied++; if (res2 !== 8'd3) begin miscompares++; $display("FAIL b2b_second_result: got %0d expected 3", res2); end
    $display("b2b add 1+2: accept1=%0d retire1=%0d accept2=%0d res1=%0d res2=%0d", acc1, ret1, acc2, res1, res2);
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    a = 4'd3; b = 4'd2; op = 2'b01; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin step(); lat++; end
    applied++; if (lat !== 5) begin miscompares++; $display("FAIL bp_latency: got %0d expected 5", lat); end
    a = 4'd9; b = 4'd9; op = 2'b00;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i % 2 == 0);
      applied++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, out_valid); end
      applied++; if (result !== 8'd6) begin miscompares++; $display("FAIL bp_hold_result[%0d]: got %0d expected 6", i, result); end
      applied++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
      $display("backpressure cycle %0d: out_valid=%b result=%0d in_ready=%b", i, out_valid, result, in_ready);
      step();
    end
    in_valid = 1'b0;
    applied++; if (out_valid !== 1'b1 || result !== 8'd6) begin miscompares++; $display("FAIL bp_before_retire: got valid=%b result=%0d expected valid=1 result=6", out_valid, result); end
    out_ready = 1'b1;
    step();
    applied++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_retire: got out_valid=%b expected 0", out_valid); end
    applied++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_after: got %b expected 1", in_ready); end
    step();
    applied++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_no_hidden_accept: got out_valid=%b expected 0", out_valid); end
    $display("backpressure retire: out_valid=%b in_ready=%b", out_valid, in_ready);
  endtask

  task automatic test_reserved();
    int lat; logic [2*W-1:0] res; logic e;
    run_txn(4'd7, 4'd7, 2'b11, lat, res, e);
    applied++; if (lat !== 1) begin miscompares++; $display("FAIL rsv3_latency: got %0d expected 1", lat); end
    applied++; if (e !== 1'b1) begin miscompares++; $display("FAIL rsv3_err: got %b expected 1", e); end
    applied++; if (res !== 8'd0) begin miscompares++; $display("FAIL rsv3_result: got %0d expected 0", res); end
    $display("op=11 7,7: lat=%0d result=%0d err=%b", lat, res, e);
    run_txn(4'd5, 4'd1, 2'b10, lat, res, e);
    applied++; if (e !== 1'b1 || res !== 8'd0) begin miscompares++; $display("FAIL rsv2: got err=%b result=%0d expected err=1 result=0", e, res); end
    $display("op=10 5,1: lat=%0d result=%0d err=%b", lat, res, e);
  endtask

`ifdef ADDMUL_OPCNT_EN
  task automatic test_opcnt();
    int lat; logic [2*W-1:0] res; logic e;
    rst_n = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    #1;
    applied++; if (op_count !== 16'd0) begin miscompares++; $display("FAIL opcnt_reset: got %0d expected 0", op_count); end
    step();
    rst_n = 1'b1;
    step();
    run_txn(4'd1, 4'd1, 2'b00, lat, res, e);
    run_txn(4'd2, 4'd3, 2'b01, lat, res, e);
    run_txn(4'd4, 4'd4, 2'b11, lat, res, e);
    run_txn(4'd5, 4'd6, 2'b00, lat, res, e);
    run_txn(4'd7, 4'd2, 2'b01, lat, res, e);
    run_txn(4'd0, 4'd0, 2'b10, lat, res, e);
    applied++; if (op_count !== 16'd6) begin miscompares++; $display("FAIL opcnt_six: got %0d expected 6", op_count); end
    $display("op_count after 6 retires: %0d", op_count);
    force dut.op_cnt_q = 16'hFFFF;
    #1;
    release dut.op_cnt_q;
    run_txn(4'd1, 4'd2, 2'b00, lat, res, e);
    applied++; if (op_count !== 16'hFFFF) begin miscompares++; $display("FAIL opcnt_saturate: got %h expected ffff", op_count); end
    $display("op_count after preload+retire: %h", op_count);
  endtask
`endif

  initial begin
    applied = 0;
    miscompares = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    op = 2'b00;
    test_reset();
    test_add();
    test_mul();
    test_boundaries();
    test_back_to_back();
    test_backpressure();
    test_reserved();
`ifdef ADDMUL_OPCNT_EN
    test_opcnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
